// File: rtl/clk_period_meter.sv
// Measures the period and high time of an asynchronous clock (sigclk) in inclk cycles, with lock and stall detection.
// Optional macro CLKMETER_DUTY_EN builds fall tracking and drives high_time; without it high_time is tied to 0.
module clk_period_meter #(
  parameter int CNT_W      = 20,
  parameter int EXP_PERIOD = 1000000,
  parameter int TOL        = 1000,
  parameter int LOCK_COUNT = 4
) (
  input  logic             inclk,
  input  logic             rst_n,
  input  logic             sigclk,
  input  logic             enable,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int STRK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  EXP_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W:0]    TOL_C   = (CNT_W + 1)'(TOL);
  localparam logic [STRK_W-1:0] LOCK_C  = STRK_W'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t             state, state_next;
  logic               sync1, sync2, sig_d;
  logic               rise;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_sat;
  logic [STRK_W-1:0]  streak, streak_inc;
  logic signed [CNT_W:0] diff, neg_diff;
  logic [CNT_W:0]     mag;
  logic               in_tol;
  logic               meas_active, do_update, do_timeout, do_clear;

  // Two-flop synchroniser plus one edge-detect flop; the fixed latency cancels out of the period.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sync1 <= sigclk;
      sync2 <= sync1;
      sig_d <= sync2;
    end
  end

  assign rise    = sync2 & ~sig_d;
  assign cnt_sat = (cnt == CNT_MAX);

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = MEAS;
        MEAS:    if (!rise && cnt_sat) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    meas_active = enable && (state == MEAS);
    do_update   = meas_active && rise;
    do_timeout  = meas_active && !rise && cnt_sat;
    do_clear    = !enable;
  end

  // Tolerance check on a signed difference one bit wider than the counter.
  assign diff       = $signed({1'b0, cnt}) - $signed({1'b0, EXP_C});
  assign neg_diff   = -diff;
  assign mag        = diff[CNT_W] ? $unsigned(neg_diff) : $unsigned(diff);
  assign in_tol     = (mag <= TOL_C);
  assign streak_inc = (streak == LOCK_C) ? LOCK_C : streak + 1'b1;

  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      period  <= '0;
      valid   <= 1'b0;
      locked  <= 1'b0;
      timeout <= 1'b0;
      streak  <= '0;
    end else begin
      valid <= 1'b0;
      if (do_clear) begin
        cnt     <= '0;
        locked  <= 1'b0;
        streak  <= '0;
        timeout <= 1'b0;
      end else begin
        if (state == IDLE)  cnt <= '0;
        else if (rise)      cnt <= CNT_W'(1);
        else if (!cnt_sat)  cnt <= cnt + 1'b1;

        if (do_update) begin
          period <= cnt;
          valid  <= 1'b1;
          if (in_tol) begin
            streak <= streak_inc;
            locked <= (streak_inc == LOCK_C);
          end else begin
            streak <= '0;
            locked <= 1'b0;
          end
        end

        if (do_timeout) begin
          timeout <= 1'b1;
          locked  <= 1'b0;
          streak  <= '0;
        end
      end
    end
  end

`ifdef CLKMETER_DUTY_EN
  logic             fall;
  logic [CNT_W-1:0] hi_latch;

  assign fall = ~sync2 & sig_d;

  // The latched high time is published only alongside the period it belongs to.
  always_ff @(posedge inclk or negedge rst_n) begin
    if (!rst_n) begin
      hi_latch  <= '0;
      high_time <= '0;
    end else begin
      if (meas_active && fall) hi_latch <= cnt;
      if (do_update)           high_time <= hi_latch;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule
